// File: rtl/alu_r32i.sv
// RV32I integer ALU for the execute stage: add/sub, compares, logic, shifts and operand copy.
// Result and zero flag are registered with one cycle of latency.
module alu_r32i #(
  parameter int unsigned dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [3:0]       alucode,
  output logic [dataW-1:0] result,
  output logic             zero
);

  localparam int unsigned ShW = $clog2(dataW);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;
  localparam logic [3:0] OpCpy  = 4'b1001;

  logic [dataW-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic [ShW-1:0]   shamt;
  logic             lt_s, lt_u;

  assign shamt = B[ShW-1:0];
  assign lt_s  = $signed(A) < $signed(B);
  assign lt_u  = A < B;

  always_comb begin
    result_d = '0;
    case (alucode)
      OpAdd:   result_d = A + B;
      OpSub:   result_d = A - B;
      OpSll:   result_d = A << shamt;
      OpSlt:   result_d = {{(dataW-1){1'b0}}, lt_s};
      OpSltu:  result_d = {{(dataW-1){1'b0}}, lt_u};
      OpXor:   result_d = A ^ B;
      OpSrl:   result_d = A >> shamt;
      OpSra:   result_d = $unsigned($signed(A) >>> shamt);
      OpOr:    result_d = A | B;
      OpAnd:   result_d = A & B;
      OpCpy:   result_d = B;
      default: result_d = '0;
    endcase
    // Flag follows the value being registered, not the one currently held.
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_r32i.sv
// Directed and randomized checks of alu_r32i; expectations are queued at drive time
// and compared one cycle later.
module tb_alu_r32i;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SSL  = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] SSR  = 4'b0101;
  localparam logic [3:0] SRA  = 4'b1101;
  localparam logic [3:0] OR   = 4'b0110;
  localparam logic [3:0] AND  = 4'b0111;
  localparam logic [3:0] CPY  = 4'b1001;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  alucode;
  logic [31:0] result;
  logic        zero;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  alu_r32i #(.dataW(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .alucode (alucode),
    .result  (result),
    .zero    (zero)
  );

  always #5 clock = ~clock;

  // Reference model, written independently of the RTL's formulation.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ext;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      ADD:  return a + b;
      SUB:  return a + ~b + 32'd1;
      SSL:  return a << sh;
      SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      SLTU: return {31'd0, a < b};
      XOR:  return a ^ b;
      SSR:  return a >> sh;
      SRA:  begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      OR:   return a | b;
      AND:  return a & b;
      CPY:  return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: queue size 0, required 1");
      return;
    end
    e = exp_q.pop_front();
    tests++;
    assert (result === e.res) else begin
      fails++;
      $error("FAIL %s result: got %h expected %h", e.tag, result, e.res);
    end
    tests++;
    assert (zero === e.zf) else begin
      fails++;
      $error("FAIL %s zero: got %b expected %b", e.tag, zero, e.zf);
    end
  endtask

  // Drive one op with a directed expected value, then check it after the next edge.
  task automatic step(input string tag, input logic rst, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
    exp_t e;
    reset   = rst;
    alucode = op;
    A       = a;
    B       = b;
    e.tag   = tag;
    e.res   = exp_res;
    e.zf    = (exp_res == 32'd0);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b1;
    A = 32'd0;
    B = 32'd0;
    alucode = ADD;

    step("reset",        1'b1, ADD,  32'd9,        32'd4,        32'd0);
    step("add_9_4",      1'b0, ADD,  32'd9,        32'd4,        32'd13);
    step("slt_9_4",      1'b0, SLT,  32'd9,        32'd4,        32'd0);
    step("slt_2_4",      1'b0, SLT,  32'd2,        32'd4,        32'd1);
    step("add_wrap",     1'b0, ADD,  32'hFFFFFFFF, 32'd1,        32'd0);
    step("sub_4_9",      1'b0, SUB,  32'd4,        32'd9,        32'hFFFFFFFB);
    step("sltu_9_4",     1'b0, SLTU, 32'd9,        32'd4,        32'd0);
    step("sltu_m2_4",    1'b0, SLTU, 32'hFFFFFFFE, 32'd4,        32'd0);
    step("sltu_m2_m1",   1'b0, SLTU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1);
    step("slt_m2_4",     1'b0, SLT,  32'hFFFFFFFE, 32'd4,        32'd1);
    step("slt_min_max",  1'b0, SLT,  32'h80000000, 32'h7FFFFFFF, 32'd1);
    step("sltu_min_max", 1'b0, SLTU, 32'h80000000, 32'h7FFFFFFF, 32'd0);
    step("slt_eq",       1'b0, SLT,  32'h12345678, 32'h12345678, 32'd0);
    step("sltu_eq",      1'b0, SLTU, 32'h12345678, 32'h12345678, 32'd0);
    step("and_9_4",      1'b0, AND,  32'd9,        32'd4,        32'd0);
    step("or_9_4",       1'b0, OR,   32'd9,        32'd4,        32'd13);
    step("xor_9_4",      1'b0, XOR,  32'd9,        32'd4,        32'd13);
    step("cpy_m9_3",     1'b0, CPY,  32'hFFFFFFF7, 32'd3,        32'd3);
    step("ssl_9_1",      1'b0, SSL,  32'd9,        32'd1,        32'd18);
    step("ssr_9_3",      1'b0, SSR,  32'd9,        32'd3,        32'd1);
    step("sra_9_3",      1'b0, SRA,  32'd9,        32'd3,        32'd1);
    step("sra_m9_3",     1'b0, SRA,  32'hFFFFFFF7, 32'd3,        32'hFFFFFFFE);
    step("ssr_m9_3",     1'b0, SSR,  32'hFFFFFFF7, 32'd3,        32'h1FFFFFFE);
    step("ssl_1_23",     1'b0, SSL,  32'd1,        32'h23,       32'd8);
    step("sra_sh0",      1'b0, SRA,  32'h8000F00D, 32'd0,        32'h8000F00D);
    step("ssr_hi_b",     1'b0, SSR,  32'h80000000, 32'hFFFFFFFF, 32'd1);
    step("add_pre_rst",  1'b0, ADD,  32'd100,      32'd23,       32'd123);
    step("reset_mid",    1'b1, ADD,  32'd100,      32'd23,       32'd0);
    step("undef_1111",   1'b0, 4'b1111, 32'd9,     32'd4,        32'd0);
    step("undef_1010",   1'b0, 4'b1010, 32'hFFFF,  32'hFFFF,     32'd0);
    step("b2b_add",      1'b0, ADD,  32'd1,        32'd1,        32'd2);
    step("b2b_sub_zero", 1'b0, SUB,  32'd7,        32'd7,        32'd0);
    step("b2b_or",       1'b0, OR,   32'hF0,       32'h0F,       32'hFF);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) a[31] = ~b[31];
      step($sformatf("rand%0d_op%b", i, op), 1'b0, op, a, b, model(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
